// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard, busy counter and WAW issue stall.
// Optional same-cycle writeback forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int NREG = 2 ** ADDR_W;
    localparam bit ZR   = (ZERO_REG != 0);

    logic [XLEN-1:0]   r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_iss_zero;
    logic              w_wb_zero;
    logic              w_wb_ok;
    logic              w_set;
    logic              w_clr;

    logic [1:0][ADDR_W-1:0] w_ra;
    logic [1:0][XLEN-1:0]   w_rdat;
    logic [1:0]             w_rbsy;

    assign w_iss_zero = ZR && (iss_rd == '0);
    assign w_wb_zero  = ZR && (wb_rd == '0);
    assign w_wb_ok    = wb_en && !w_wb_zero;

    assign iss_ready  = w_iss_zero || !r_busy[iss_rd];

    // An accepted issue always targets a clear bit, so a same-register writeback never
    // clears it in that cycle: the set wins and the counter only increments.
    assign w_set = iss_valid && iss_ready && !w_iss_zero;
    assign w_clr = w_wb_ok && r_busy[wb_rd] && !(w_set && (iss_rd == wb_rd));

    assign w_ra = {rs2_addr, rs1_addr};

    for (genvar gp = 0; gp < 2; gp++) begin : g_rd
        always_comb begin
            w_rdat[gp] = r_regs[w_ra[gp]];
            w_rbsy[gp] = r_busy[w_ra[gp]];
`ifdef REGFILE_BYPASS_EN
            if (w_wb_ok && (wb_rd == w_ra[gp])) begin
                w_rdat[gp] = wb_data;
                w_rbsy[gp] = 1'b0;
            end
`endif
            if (ZR && (w_ra[gp] == '0)) begin
                w_rdat[gp] = '0;
                w_rbsy[gp] = 1'b0;
            end
        end
    end

    assign rs1_data = w_rdat[0];
    assign rs2_data = w_rdat[1];
    assign rs1_busy = w_rbsy[0];
    assign rs2_busy = w_rbsy[1];
    assign busy_cnt = r_busy_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wb_ok) r_regs[wb_rd] <= wb_data;
            if (w_clr)   r_busy[wb_rd] <= 1'b0;
            if (w_set)   r_busy[iss_rd] <= 1'b1;
            case ({w_set, w_clr})
                2'b10:   r_busy_cnt <= r_busy_cnt + 1'b1;
                2'b01:   r_busy_cnt <= r_busy_cnt - 1'b1;
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table through a scoreboard queue, then
// hand sequences for fill-to-31, saturation and reset-over-writeback.
module tb_regfile_sb;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rs1_addr, rs2_addr, iss_rd, wb_rd;
    logic [XLEN-1:0]   rs1_data, rs2_data, wb_data;
    logic              rs1_busy, rs2_busy, iss_valid, iss_ready, wb_en;
    logic [ADDR_W:0]   busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic              iv;
        logic [ADDR_W-1:0] ird;
        logic              we;
        logic [ADDR_W-1:0] wrd;
        logic [XLEN-1:0]   wd;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [XLEN-1:0]   e_d1;
        logic              e_b1;
        logic [XLEN-1:0]   e_d2;
        logic              e_b2;
        logic              e_rdy;
        logic [ADDR_W:0]   e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];
    vec_t sb [$];

    function automatic vec_t mk(input logic iv, input int ird, input logic we, input int wrd,
                                input logic [XLEN-1:0] wd, input int a1, input int a2,
                                input logic [XLEN-1:0] d1, input logic b1,
                                input logic [XLEN-1:0] d2, input logic b2,
                                input logic rdy, input int cnt);
        vec_t v;
        v.iv = iv;  v.ird = ADDR_W'(ird); v.we = we; v.wrd = ADDR_W'(wrd); v.wd = wd;
        v.a1 = ADDR_W'(a1); v.a2 = ADDR_W'(a2);
        v.e_d1 = d1; v.e_b1 = b1; v.e_d2 = d2; v.e_b2 = b2;
        v.e_rdy = rdy; v.e_cnt = (ADDR_W+1)'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    initial begin
        vec_t e;
        rst = 1'b0; rs1_addr = '0; rs2_addr = '0;
        idle();

        // idx: iv ird we wrd wd a1 a2 | d1 b1 d2 b2 rdy cnt
        vt[0]  = mk(0, 5,  0, 0,  0, 0, 31, 0, 0, 0, 0, 1, 0);
        vt[1]  = mk(0, 0,  1, 5,  32'hDEADBEEF, 5, 0, BYP ? 32'hDEADBEEF : 0, 0, 0, 0, 1, 0);
        vt[2]  = mk(0, 0,  1, 0,  32'h1234, 5, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1, 0);
        vt[3]  = mk(1, 7,  0, 0,  0, 0, 5, 0, 0, 32'hDEADBEEF, 0, 1, 0);
        vt[4]  = mk(1, 7,  0, 0,  0, 7, 7, 0, 1, 0, 1, 0, 1);
        vt[5]  = mk(0, 7,  1, 7,  77, 7, 7, BYP ? 77 : 0, !BYP, BYP ? 77 : 0, !BYP, 0, 1);
        vt[6]  = mk(0, 7,  0, 0,  0, 7, 7, 77, 0, 77, 0, 1, 0);
        vt[7]  = mk(1, 3,  0, 0,  0, 3, 3, 0, 0, 0, 0, 1, 0);
        vt[8]  = mk(1, 3,  1, 3,  33, 3, 0, BYP ? 33 : 0, !BYP, 0, 0, 0, 1);
        vt[9]  = mk(0, 3,  0, 0,  0, 3, 0, 33, 0, 0, 0, 1, 0);
        vt[10] = mk(1, 3,  1, 3,  44, 3, 0, BYP ? 44 : 33, 0, 0, 0, 1, 0);
        vt[11] = mk(0, 3,  0, 0,  0, 3, 0, 44, 1, 0, 0, 0, 1);
        vt[12] = mk(0, 0,  1, 12, 32'hC, 12, 3, BYP ? 32'hC : 0, 0, 44, 1, 1, 1);
        vt[13] = mk(0, 0,  0, 0,  0, 12, 3, 32'hC, 0, 44, 1, 1, 1);
        vt[14] = mk(1, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1);
        vt[15] = mk(0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1);
        vt[16] = mk(0, 0,  1, 9,  32'hA5A5A5A5, 9, 9, BYP ? 32'hA5A5A5A5 : 0, 0,
                    BYP ? 32'hA5A5A5A5 : 0, 0, 1, 1);
        vt[17] = mk(0, 0,  0, 0,  0, 9, 3, 32'hA5A5A5A5, 0, 44, 1, 1, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("reset_cnt", XLEN'(busy_cnt), 0);

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            iss_valid = vt[i].iv; iss_rd = vt[i].ird;
            wb_en = vt[i].we; wb_rd = vt[i].wrd; wb_data = vt[i].wd;
            rs1_addr = vt[i].a1; rs2_addr = vt[i].a2;
            sb.push_back(vt[i]);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d_rs1_data", i), rs1_data, e.e_d1);
            chk($sformatf("v%0d_rs1_busy", i), XLEN'(rs1_busy), XLEN'(e.e_b1));
            chk($sformatf("v%0d_rs2_data", i), rs2_data, e.e_d2);
            chk($sformatf("v%0d_rs2_busy", i), XLEN'(rs2_busy), XLEN'(e.e_b2));
            chk($sformatf("v%0d_iss_ready", i), XLEN'(iss_ready), XLEN'(e.e_rdy));
            chk($sformatf("v%0d_busy_cnt", i), XLEN'(busy_cnt), XLEN'(e.e_cnt));
        end

        // clear reg 3, then fill 1..31
        @(negedge clk);
        idle(); wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h3;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            idle(); iss_valid = 1'b1; iss_rd = ADDR_W'(r);
            #1;
            chk($sformatf("fill_rdy_%0d", r), XLEN'(iss_ready), 1);
        end
        @(negedge clk);
        idle();
        #1;
        chk("fill_cnt", XLEN'(busy_cnt), 31);
        iss_rd = 5'd0;
        #1;
        chk("fill_rdy_r0", XLEN'(iss_ready), 1);
        iss_rd = 5'd17; rs1_addr = 5'd17; rs2_addr = 5'd17;
        #1;
        chk("fill_rdy_r17", XLEN'(iss_ready), 0);
        chk("fill_rs1_busy17", XLEN'(rs1_busy), 1);
        chk("fill_rs2_busy17", XLEN'(rs2_busy), 1);

        // stalled issue when all busy: counter must hold
        iss_valid = 1'b1; iss_rd = 5'd5;
        @(negedge clk);
        idle();
        #1;
        chk("sat_cnt", XLEN'(busy_cnt), 31);

        // reset beats simultaneous writeback and issue
        rst = 1'b0; wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        rst = 1'b1; idle();
        #1;
        chk("rst_cnt", XLEN'(busy_cnt), 0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = ADDR_W'(a); rs2_addr = ADDR_W'(31 - a); iss_rd = ADDR_W'(a);
            #1;
            chk($sformatf("rst_rs1_data_%0d", a), rs1_data, 0);
            chk($sformatf("rst_rs2_data_%0d", a), rs2_data, 0);
            chk($sformatf("rst_busy_%0d", a), XLEN'({rs1_busy, rs2_busy}), 0);
            chk($sformatf("rst_rdy_%0d", a), XLEN'(iss_ready), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
